// File: rtl/jk_cmd_sequencer.sv
// JK flip-flop command sequencer: drives j/k for cmd_len+1 cycles per command.
// Optional JK_SEQ_BACK2BACK_EN removes the GAP cycle for back-to-back commands.
module jk_cmd_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             q_model
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             j_n, k_n, busy_n, done_n, ready_n, q_n;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
      q_model   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      j         <= j_n;
      k         <= k_n;
      busy      <= busy_n;
      done      <= done_n;
      cmd_ready <= ready_n;
      q_model   <= q_n;
    end
  end

  // Mirror of the FF: reacts to the {j,k} it currently sees.
  always_comb begin
    q_n = q_model;
    unique case ({j, k})
      2'b01:   q_n = 1'b0;
      2'b10:   q_n = 1'b1;
      2'b11:   q_n = ~q_model;
      default: q_n = q_model;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    j_n     = j;
    k_n     = k;
    busy_n  = busy;
    done_n  = 1'b0;
    ready_n = cmd_ready;
    unique case (state)
      IDLE: begin
        j_n     = 1'b0;
        k_n     = 1'b0;
        busy_n  = 1'b0;
        ready_n = 1'b1;
        if (accept) begin
          state_n    = DRIVE;
          cnt_n      = cmd_len;
          {j_n, k_n} = cmd_op;
          busy_n     = 1'b1;
          ready_n    = 1'b0;
`ifdef JK_SEQ_BACK2BACK_EN
          if (cmd_len == '0) begin
            done_n  = 1'b1;
            ready_n = 1'b1;
          end
`endif
        end
      end
      DRIVE: begin
`ifdef JK_SEQ_BACK2BACK_EN
        if (cnt == '0) begin
          if (accept) begin
            cnt_n      = cmd_len;
            {j_n, k_n} = cmd_op;
            busy_n     = 1'b1;
            ready_n    = 1'b0;
            if (cmd_len == '0) begin
              done_n  = 1'b1;
              ready_n = 1'b1;
            end
          end else begin
            state_n = IDLE;
            j_n     = 1'b0;
            k_n     = 1'b0;
            busy_n  = 1'b0;
            ready_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
          // Flag the final drive cycle one edge early.
          if (cnt == CNT_W'(1)) begin
            done_n  = 1'b1;
            ready_n = 1'b1;
          end
        end
`else
        if (cnt == '0) begin
          state_n = GAP;
          j_n     = 1'b0;
          k_n     = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
`endif
      end
`ifndef JK_SEQ_BACK2BACK_EN
      GAP: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end
`endif
      default: begin
        state_n = IDLE;
        j_n     = 1'b0;
        k_n     = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: stimulus pushes expected busy-cycle
// records, a negedge monitor pops and compares them.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       j, k, busy, done, q_model;

  typedef struct {
    logic j;
    logic k;
    logic done;
    logic q;
  } rec_t;

  rec_t exp_q[$];
  rec_t r;
  logic q_run = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  jk_cmd_sequencer #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [3:0] len);
    int w = 0;
    int n = int'(len);
    rec_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= n; i++) begin
      e.j = op[1];
      e.k = op[0];
`ifdef JK_SEQ_BACK2BACK_EN
      e.done = (i == n);
`else
      e.done = 1'b0;
`endif
      e.q = q_run;
      exp_q.push_back(e);
      q_run = jk_next(q_run, op[1], op[0]);
    end
`ifndef JK_SEQ_BACK2BACK_EN
    e.j = 1'b0;
    e.k = 1'b0;
    e.done = 1'b1;
    e.q = q_run;
    exp_q.push_back(e);
`endif
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || exp_q.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_busy", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("drive_j", int'(j), int'(r.j));
          chk("drive_k", int'(k), int'(r.k));
          chk("drive_done", int'(done), int'(r.done));
          chk("drive_q", int'(q_model), int'(r.q));
        end
      end else begin
        chk("idle_jk", int'({j, k}), 0);
        chk("idle_done", int'(done), 0);
      end
    end
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_jk", int'({j, k}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_q", int'(q_model), 0);
      chk("rst_ready", int'(cmd_ready), 0);
      chk("rst_done", int'(done), 0);
    end
    rst_n = 1'b1;
    #1 chk("ready_before_edge", int'(cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", int'(cmd_ready), 1);

    send(2'b10, 4'd0);
    send(2'b01, 4'd0);
    wait_idle();

    send(2'b10, 4'd0);
    send(2'b11, 4'd3);
    wait_idle();

    send(2'b00, 4'd3);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 4'd2;
    repeat (2) @(negedge clk);
    chk("drop_not_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    wait_idle();

    send(2'b01, 4'd2);
    send(2'b10, 4'd1);
    wait_idle();

    send(2'b11, 4'd15);
    wait_idle();

    send(2'b11, 4'd15);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_jk", int'({j, k}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(cmd_ready), 0);
    chk("abort_q", int'(q_model), 0);
    exp_q.delete();
    q_run = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_hold_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_ready_back", int'(cmd_ready), 1);

    send(2'b10, 4'd1);
    send(2'b01, 4'd1);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
